// File: rtl/hamming_tx_packer_if.sv
// Handshake bundle between a byte source, the Hamming(15,11) packer and the
// downstream 15-bit codeword consumer. The packer itself uses the slave view.
interface hamming_tx_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        flush;
  logic [3:0]  err_pos;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_code;
  logic [15:0] word_cnt;

  modport slave (
    input  in_valid, in_data, flush, err_pos, out_ready,
    output in_ready, out_valid, out_code, word_cnt
  );

  modport master (
    output in_valid, in_data, flush, err_pos, out_ready,
    input  in_ready, out_valid, out_code, word_cnt
  );
endinterface

// File: rtl/hamming_tx_packer.sv
// Hamming(15,11) transmitter: packs bytes LSB-first into 11-bit words,
// encodes them and presents codewords on a registered valid/ready output.
//
// state | meaning
// FILL  | accepting bytes, emitting whenever 11 bits are available
// DRAIN | flush pending: no new bytes, emit full words then the padded tail
module hamming_tx_packer (
  input logic                clk,
  input logic                rst_n,
  hamming_tx_packer_if.slave bus
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [17:0] acc, acc_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        in_rdy;
  logic        accept;
  logic        slot_free;
  logic        emit_norm;
  logic        emit_pad;
  logic        load;
  logic [11:1] d_word;
  logic [14:0] flip_mask;
  logic        out_valid_q;
  logic [14:0] out_code_q;
  logic [15:0] word_cnt_q;

  // Codeword bit k (1..15) sits at out_code[k-1]; parity bits at powers of two.
  function automatic logic [14:0] encode(input logic [11:1] d);
    logic p1, p2, p4, p8;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1};
  endfunction

  // in_ready depends on registers only, so no path from out_ready.
  assign in_rdy    = (cnt <= 5'd10) && (state == FILL);
  assign accept    = bus.in_valid && in_rdy;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign emit_norm = (cnt >= 5'd11) && slot_free;
  assign emit_pad  = (state == DRAIN) && (cnt != 5'd0) && (cnt <= 5'd10) && slot_free;
  assign d_word    = acc[10:0];
  assign flip_mask = (bus.err_pos == 4'd0) ? 15'd0 : (15'd1 << (bus.err_pos - 4'd1));

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.word_cnt  = word_cnt_q;

  // Accumulator update: byte append, full-word pop or padded-tail pop.
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    load    = 1'b0;
    if (accept) begin
      acc_nxt = acc | (18'(bus.in_data) << cnt);
      cnt_nxt = cnt + 5'd8;
    end else if (emit_norm) begin
      load    = 1'b1;
      acc_nxt = acc >> 11;
      cnt_nxt = cnt - 5'd11;
    end else if (emit_pad) begin
      // bits above cnt are already zero, so acc[10:0] is the padded word
      load    = 1'b1;
      acc_nxt = '0;
      cnt_nxt = 5'd0;
    end
  end

  // Flush sequencing; the flush decision looks at the post-accept bit count.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (bus.flush && (cnt_nxt != 5'd0)) state_nxt = DRAIN;
      // cnt == 0 in DRAIN only if the last full word already left; nothing to pad
      DRAIN: if (emit_pad || (cnt == 5'd0)) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Accumulator and bit-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Output register: load on emit, clear valid after a transfer, count transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_code_q  <= encode(d_word) ^ flip_mask;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && bus.out_ready) word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

endmodule
